// File: rtl/ir_pkg.sv
// ir_pkg: shared definitions for the NEC IR decoder.
//   - decoder state enum
//   - phase window limits, in prescaled ticks, inclusive on both ends
//   - button codes shared with the mode FSM
//   - in_win(): inclusive window test used by the decoder FSM
package ir_pkg;

    localparam int TICK_DIV_DEF      = 2812;  // 56.24 us per tick at 50 MHz
    localparam int TIMEOUT_TICKS_DEF = 200;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD_MARK,
        ST_LEAD_SPACE,
        ST_DATA_MARK,
        ST_DATA_SPACE,
        ST_CHECK
    } ir_state_t;

    localparam logic [7:0] LEAD_MARK_MIN  = 8'd140;
    localparam logic [7:0] LEAD_MARK_MAX  = 8'd180;
    localparam logic [7:0] LEAD_SPACE_MIN = 8'd70;
    localparam logic [7:0] LEAD_SPACE_MAX = 8'd90;
    localparam logic [7:0] REP_SPACE_MIN  = 8'd32;
    localparam logic [7:0] REP_SPACE_MAX  = 8'd48;
    localparam logic [7:0] BIT_MARK_MIN   = 8'd6;
    localparam logic [7:0] BIT_MARK_MAX   = 8'd14;
    localparam logic [7:0] BIT0_SPACE_MIN = 8'd6;
    localparam logic [7:0] BIT0_SPACE_MAX = 8'd14;
    localparam logic [7:0] BIT1_SPACE_MIN = 8'd24;
    localparam logic [7:0] BIT1_SPACE_MAX = 8'd36;

    localparam logic [7:0] BTN_CAM  = 8'h0f;
    localparam logic [7:0] BTN_IR   = 8'h13;
    localparam logic [7:0] BTN_IDLE = 8'h10;

    function automatic logic in_win(input logic [7:0] v,
                                    input logic [7:0] lo,
                                    input logic [7:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/ir_nec_decoder_if.sv
// ir_nec_decoder_if: IR receiver line in, decoded command/address and strobes out.
//   IR_RX       raw receiver output, active-low (0 = mark)
//   IR_button   last accepted command byte
//   ir_address  address byte of the last accepted frame
//   ir_valid    one-cycle pulse, new frame accepted
//   ir_repeat   one-cycle pulse, NEC repeat frame
//   ir_error    one-cycle pulse, frame aborted or rejected
// master = the decoder, slave = the consumer (mode FSM) plus the line source.
interface ir_nec_decoder_if;
    logic       IR_RX;
    logic [7:0] IR_button;
    logic [7:0] ir_address;
    logic       ir_valid;
    logic       ir_repeat;
    logic       ir_error;

    modport master (
        input  IR_RX,
        output IR_button, ir_address, ir_valid, ir_repeat, ir_error
    );

    modport slave (
        output IR_RX,
        input  IR_button, ir_address, ir_valid, ir_repeat, ir_error
    );
endinterface

// File: rtl/ir_rx_sync.sv
// ir_rx_sync: 2-flop synchronizer for the asynchronous IR line plus edge detector.
//   clk_50   system clock
//   reset    asynchronous active-high reset (flops reset to 1 = idle line)
//   rx_in    raw asynchronous IR line
//   rx_s     synchronized line level
//   rx_rise  one-cycle pulse on a synchronized 0->1 transition
//   rx_fall  one-cycle pulse on a synchronized 1->0 transition
// An edge on rx_in shows up on rx_rise/rx_fall two cycles later.
module ir_rx_sync (
    input  logic clk_50,
    input  logic reset,
    input  logic rx_in,
    output logic rx_s,
    output logic rx_rise,
    output logic rx_fall
);
    logic meta_q, sync_q, prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, giving a true shift chain.
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rx_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rx_s    = sync_q;
    assign rx_rise = ~prev_q &  sync_q;
    assign rx_fall =  prev_q & ~sync_q;
endmodule

// File: rtl/ir_nec_decoder.sv
// ir_nec_decoder: NEC IR frame decoder.
//   clk_50  system clock (50 MHz)
//   reset   asynchronous active-high reset
//   bus     ir_nec_decoder_if.master: IR_RX in; IR_button, ir_address,
//           ir_valid, ir_repeat, ir_error out
// Mark/space widths are measured in ticks of TICK_DIV clocks; a phase longer
// than TIMEOUT_TICKS aborts the frame. Defining IR_NEC_CHECK_EN makes the
// decoder reject frames whose address/command inverse bytes do not match.
module ir_nec_decoder
    import ir_pkg::*;
#(
    parameter int TICK_DIV      = TICK_DIV_DEF,
    parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
    input  logic              clk_50,
    input  logic              reset,
    ir_nec_decoder_if.master  bus
);
    localparam int             PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRE_LAST    = PW'(TICK_DIV - 1);
    localparam logic [7:0]     TIMEOUT_CNT = 8'(TIMEOUT_TICKS);

    logic rx_level_unused;  // level is for debug only; decoding works on edges
    logic rx_rise, rx_fall;

    ir_rx_sync u_sync (
        .clk_50  (clk_50),
        .reset   (reset),
        .rx_in   (bus.IR_RX),
        .rx_s    (rx_level_unused),
        .rx_rise (rx_rise),
        .rx_fall (rx_fall)
    );

    // Prescaler and phase counter; both restart on any edge so the phase
    // counter holds the width of the phase that the edge just closed.
    logic [PW-1:0] pre_q;
    logic [7:0]    phase_q;

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            pre_q   <= '0;
            phase_q <= '0;
        end else if (rx_rise || rx_fall) begin
            pre_q   <= '0;
            phase_q <= '0;
        end else if (pre_q == PRE_LAST) begin
            pre_q <= '0;
            if (phase_q != 8'hff) phase_q <= phase_q + 8'd1;
        end else begin
            pre_q <= pre_q + PW'(1);
        end
    end

    ir_state_t   state_q, state_d;
    logic [31:0] frame_q;
    logic [4:0]  bit_idx_q;
    logic [7:0]  button_q, addr_q;
    logic        valid_q, repeat_q, error_q;
    logic        valid_d, repeat_d, error_d;
    logic        shift_en, bit_val, clr_idx, inc_idx, load;
    logic        frame_ok;

`ifdef IR_NEC_CHECK_EN
    assign frame_ok = (frame_q[15:8]  == ~frame_q[7:0]) &&
                      (frame_q[31:24] == ~frame_q[23:16]);
`else
    assign frame_ok = 1'b1;
`endif

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a variable unassigned, which would infer a latch.
    always_comb begin
        state_d  = state_q;
        valid_d  = 1'b0;
        repeat_d = 1'b0;
        error_d  = 1'b0;
        shift_en = 1'b0;
        bit_val  = 1'b0;
        clr_idx  = 1'b0;
        inc_idx  = 1'b0;
        load     = 1'b0;

        // Timeout outranks an edge arriving in the same cycle.
        if (state_q != ST_IDLE && phase_q >= TIMEOUT_CNT) begin
            error_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_fall) state_d = ST_LEAD_MARK;
                end
                ST_LEAD_MARK: begin
                    if (rx_rise) begin
                        if (in_win(phase_q, LEAD_MARK_MIN, LEAD_MARK_MAX)) state_d = ST_LEAD_SPACE;
                        else                                              error_d = 1'b1;
                    end
                end
                ST_LEAD_SPACE: begin
                    if (rx_fall) begin
                        if (in_win(phase_q, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
                            clr_idx = 1'b1;
                            state_d = ST_DATA_MARK;
                        end else if (in_win(phase_q, REP_SPACE_MIN, REP_SPACE_MAX)) begin
                            repeat_d = 1'b1;
                            state_d  = ST_IDLE;
                        end else begin
                            error_d = 1'b1;
                        end
                    end
                end
                ST_DATA_MARK: begin
                    if (rx_rise) begin
                        if (in_win(phase_q, BIT_MARK_MIN, BIT_MARK_MAX)) state_d = ST_DATA_SPACE;
                        else                                            error_d = 1'b1;
                    end
                end
                ST_DATA_SPACE: begin
                    if (rx_fall) begin
                        if (in_win(phase_q, BIT0_SPACE_MIN, BIT0_SPACE_MAX) ||
                            in_win(phase_q, BIT1_SPACE_MIN, BIT1_SPACE_MAX)) begin
                            shift_en = 1'b1;
                            bit_val  = in_win(phase_q, BIT1_SPACE_MIN, BIT1_SPACE_MAX);
                            if (bit_idx_q == 5'd31) begin
                                state_d = ST_CHECK;
                            end else begin
                                inc_idx = 1'b1;
                                state_d = ST_DATA_MARK;
                            end
                        end else begin
                            error_d = 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    state_d = ST_IDLE;
                    if (frame_ok) begin
                        load    = 1'b1;
                        valid_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (error_d) state_d = ST_IDLE;
    end

    // Bits arrive LSB first: shifting in from the top leaves bit 0 at frame[0].
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            frame_q   <= '0;
            bit_idx_q <= '0;
            button_q  <= 8'h00;
            addr_q    <= 8'h00;
            valid_q   <= 1'b0;
            repeat_q  <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            if (shift_en) frame_q <= {bit_val, frame_q[31:1]};
            if (clr_idx)      bit_idx_q <= '0;
            else if (inc_idx) bit_idx_q <= bit_idx_q + 5'd1;
            if (load) begin
                button_q <= frame_q[23:16];
                addr_q   <= frame_q[7:0];
            end
            valid_q  <= valid_d;
            repeat_q <= repeat_d;
            error_q  <= error_d;
        end
    end

    assign bus.IR_button  = button_q;
    assign bus.ir_address = addr_q;
    assign bus.ir_valid   = valid_q;
    assign bus.ir_repeat  = repeat_q;
    assign bus.ir_error   = error_q;
endmodule

// File: tb/tb_ir_nec_decoder.sv
// tb_ir_nec_decoder: directed + randomized NEC frames against a frame-level
// reference model. The decoder runs with a 3-clock tick so whole frames fit
// in a short run. A phase driven for c*TD+1 clocks is measured as c ticks.
module tb_ir_nec_decoder;
    import ir_pkg::*;

    localparam int TD = 3;
    localparam int TO = 200;

    logic clk_50 = 1'b0;
    logic reset  = 1'b1;

    ir_nec_decoder_if bus ();

    ir_nec_decoder #(.TICK_DIV(TD), .TIMEOUT_TICKS(TO)) dut (
        .clk_50 (clk_50),
        .reset  (reset),
        .bus    (bus)
    );

    always #10 clk_50 = ~clk_50;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_valid = 0, n_rep = 0, n_err = 0;
    int valid_cyc = 0, err_cyc = 0;
    logic [7:0] valid_btn = 8'h00;
    int edge_cyc = 0, stop_cyc = 0;
    int v0 = 0, r0 = 0, e0 = 0;
    logic [7:0] exp_btn  = 8'h00;
    logic [7:0] exp_addr = 8'h00;

    always @(posedge clk_50) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor, sampled on the falling clock edge.
    always @(negedge clk_50) begin
        if (bus.ir_valid) begin
            n_valid++;
            valid_cyc = cyc;
            valid_btn = bus.IR_button;
        end
        if (bus.ir_repeat) n_rep++;
        if (bus.ir_error) begin
            n_err++;
            err_cyc = cyc;
        end
        if (bus.ir_valid || bus.ir_repeat || bus.ir_error)
            check("one_strobe", 32'(bus.ir_valid) + 32'(bus.ir_repeat) + 32'(bus.ir_error), 32'd1);
    end

    // Drive one line level for 'ticks' ticks; called on a falling clock edge.
    task automatic phase(input logic lvl, input int ticks);
        bus.IR_RX = lvl;
        edge_cyc  = cyc;
        repeat (ticks * TD + 1) @(negedge clk_50);
    endtask

    task automatic leader(input int lm, input int ls);
        phase(1'b0, lm);
        phase(1'b1, ls);
    endtask

    // Send leader and the first nbits bits of w (LSB first); a full frame
    // also gets its stop mark. bnd selects window-edge timings.
    task automatic send_frame(input logic [31:0] w, input int nbits, input bit bnd);
        int m, s;
        if (bnd) leader(140, 90);
        else     leader($urandom_range(145, 175), $urandom_range(72, 88));
        for (int i = 0; i < nbits; i++) begin
            if (bnd) begin
                m = (i % 2 == 1) ? 14 : 6;
                s = w[i] ? ((i % 2 == 1) ? 36 : 24) : ((i % 2 == 1) ? 14 : 6);
            end else begin
                m = $urandom_range(6, 14);
                s = w[i] ? $urandom_range(24, 36) : $urandom_range(6, 14);
            end
            phase(1'b0, m);
            phase(1'b1, s);
        end
        if (nbits == 32) begin
            phase(1'b0, 10);
            stop_cyc = edge_cyc;
            phase(1'b1, 30);
        end
    endtask

    task automatic snap();
        v0 = n_valid;
        r0 = n_rep;
        e0 = n_err;
    endtask

    task automatic expect_strobes(input string tag, input int dv, input int dr, input int de);
        check({tag, "_valid_cnt"},  32'(n_valid - v0), 32'(dv));
        check({tag, "_repeat_cnt"}, 32'(n_rep - r0),   32'(dr));
        check({tag, "_error_cnt"},  32'(n_err - e0),   32'(de));
    endtask

    // Frame-level reference: accept unless inverse checking is built in and
    // either inverse byte is wrong.
    task automatic expect_frame(input string tag, input logic [31:0] w);
        bit ok;
`ifdef IR_NEC_CHECK_EN
        ok = (w[15:8] == ~w[7:0]) && (w[31:24] == ~w[23:16]);
`else
        ok = 1'b1;
`endif
        if (ok) begin
            exp_btn  = w[23:16];
            exp_addr = w[7:0];
        end
        expect_strobes(tag, ok ? 1 : 0, 0, ok ? 0 : 1);
        check({tag, "_button"},  32'(bus.IR_button),  32'(exp_btn));
        check({tag, "_address"}, 32'(bus.ir_address), 32'(exp_addr));
        if (ok) begin
            check({tag, "_valid_lat"}, 32'(valid_cyc - stop_cyc), 32'd4);
            check({tag, "_btn_at_valid"}, 32'(valid_btn), 32'(exp_btn));
        end else begin
            check({tag, "_error_lat"}, 32'(err_cyc - stop_cyc), 32'd4);
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [7:0] a, c, ia, ic;
        a  = 8'($urandom);
        c  = 8'($urandom);
        ia = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ~a;
        ic = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ~c;
        return {ic, c, ia, a};
    endfunction

    initial begin
        logic [31:0] w;
        bus.IR_RX = 1'b1;
        reset     = 1'b1;
        repeat (5) @(negedge clk_50);
        check("rst_button",  32'(bus.IR_button),  32'h00);
        check("rst_address", 32'(bus.ir_address), 32'h00);
        check("rst_strobes", {29'd0, bus.ir_valid, bus.ir_repeat, bus.ir_error}, 32'd0);
        check("rst_state",   32'(dut.state_q),    32'(ST_IDLE));
        reset = 1'b0;
        phase(1'b1, 20);

        // Valid frame: address 00, command 0f.
        snap();
        w = {~BTN_CAM, BTN_CAM, 8'hff, 8'h00};
        send_frame(w, 32, 1'b0);
        expect_frame("cam_frame", w);

        // Repeat frame: leader mark, 40-tick space, stop mark.
        snap();
        leader(160, 40);
        phase(1'b0, 10);
        phase(1'b1, 30);
        expect_strobes("repeat", 0, 1, 0);
        check("repeat_button", 32'(bus.IR_button), 32'(exp_btn));

        // Command 13 with corrupted inverse ED instead of EC.
        snap();
        w = {8'hed, BTN_IR, 8'hff, 8'h00};
        send_frame(w, 32, 1'b0);
        expect_frame("bad_inverse", w);

        // Line held low after the leader space: timeout at 200 ticks.
        snap();
        leader(160, 80);
        phase(1'b0, 213);
        check("timeout_lat", 32'(err_cyc - edge_cyc), 32'(TO * TD + 4));
        expect_strobes("timeout", 0, 0, 1);
        check("timeout_state", 32'(dut.state_q), 32'(ST_IDLE));
        phase(1'b1, 30);

        // Reset after bit 16, then a full frame for 10.
        snap();
        send_frame(rand_word(), 17, 1'b0);
        reset = 1'b1;
        repeat (5) @(negedge clk_50);
        reset = 1'b0;
        exp_btn  = 8'h00;
        exp_addr = 8'h00;
        phase(1'b1, 30);
        expect_strobes("mid_reset", 0, 0, 0);
        check("mid_reset_button", 32'(bus.IR_button), 32'h00);
        snap();
        w = {~BTN_IDLE, BTN_IDLE, 8'hb7, 8'h48};
        send_frame(w, 32, 1'b0);
        expect_frame("idle_frame", w);

        // 20-tick bit space, between the bit-0 and bit-1 windows.
        snap();
        leader(160, 80);
        for (int i = 0; i < 3; i++) begin
            phase(1'b0, 10);
            phase(1'b1, 10);
        end
        phase(1'b0, 10);
        phase(1'b1, 20);
        phase(1'b0, 10);
        phase(1'b1, 30);
        expect_strobes("gap_space", 0, 0, 1);
        snap();
        w = {~8'h5a, 8'h5a, ~8'h21, 8'h21};
        send_frame(w, 32, 1'b0);
        expect_frame("after_gap", w);

        // Window-edge timings throughout a frame.
        snap();
        w = {~8'hc3, 8'hc3, ~8'h96, 8'h96};
        send_frame(w, 32, 1'b1);
        expect_frame("boundary", w);

        // Leader mark just over its window; leader space just under.
        snap();
        phase(1'b0, 181);
        phase(1'b1, 30);
        expect_strobes("long_leader", 0, 0, 1);
        snap();
        leader(160, 69);
        phase(1'b0, 10);
        phase(1'b1, 30);
        expect_strobes("short_lspace", 0, 0, 1);
        check("short_lspace_button", 32'(bus.IR_button), 32'(exp_btn));

        // Random frames, some with wrong inverse bytes.
        for (int k = 0; k < 4; k++) begin
            snap();
            w = rand_word();
            send_frame(w, 32, 1'b0);
            expect_frame($sformatf("rand%0d", k), w);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
